ls_unit: RTL

LS_UNIT -- requirements
Module: ls_unit

---
 rtl/ls_unit_pkg.sv | 17 +
 rtl/ls_unit_align.sv | 53 +++++
 rtl/ls_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ls_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package ls_unit_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/ls_unit_align.sv
// Combinational lane logic: byte enables, store replication, load lane select/extend.
module ls_align
   import ls_unit_pkg::*;
(
   input  size_e       size,
   input  logic        sgn,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] dout,
   output logic        bad_align,
   output logic [3:0]  be,
   output logic [31:0] din,
   output logic [31:0] rdata
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = dout[7:0];
      case (addr_lo)
         2'd1:    byte_lane = dout[15:8];
         2'd2:    byte_lane = dout[23:16];
         2'd3:    byte_lane = dout[31:24];
         default: byte_lane = dout[7:0];
      endcase
      half_lane = addr_lo[1] ? dout[31:16] : dout[15:0];

      bad_align = 1'b0;
      be        = 4'b0000;
      din       = wdata;
      rdata     = dout;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << addr_lo;
            din   = {4{wdata[7:0]}};
            rdata = sgn ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
         end
         SZ_HALF: begin
            bad_align = addr_lo[0];
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            din       = {2{wdata[15:0]}};
            rdata     = sgn ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
         end
         SZ_WORD: begin
            bad_align = (addr_lo != 2'b00);
            be        = 4'b1111;
         end
         default: bad_align = 1'b1;
      endcase
   end

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: accepts one CPU request, performs a single-cycle data-memory
// access, then holds the response until the CPU takes it.
module ls_unit
   import ls_unit_pkg::*;
#(
   parameter int AW = 13
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Req_Valid,
   output logic          Req_Ready,
   input  logic          Req_We,
   input  logic [1:0]    Req_Size,
   input  logic          Req_Signed,
   input  logic [31:0]   Req_Addr,
   input  logic [31:0]   Req_Wdata,
   output logic          Rsp_Valid,
   input  logic          Rsp_Ready,
   output logic [31:0]   Rsp_Rdata,
   output logic          Rsp_Err,
   output logic [7:0]    Err_Cnt,
   output logic [AW-1:0] Dm_A,
   output logic [31:0]   Dm_Din,
   output logic [3:0]    Dm_BE,
   output logic          Dm_We,
   input  logic [31:0]   Dm_Dout
);

   state_e      state, state_nxt;
   logic        req_we, req_sgn;
   size_e       req_size;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  err_cnt;
   logic        bad_align, out_of_range, req_err;
   logic [3:0]  lane_be;
   logic [31:0] lane_din, lane_rdata;

   ls_align u_align (
      .size      (req_size),
      .sgn       (req_sgn),
      .addr_lo   (req_addr[1:0]),
      .wdata     (req_wdata),
      .dout      (Dm_Dout),
      .bad_align (bad_align),
      .be        (lane_be),
      .din       (lane_din),
      .rdata     (lane_rdata)
   );

   // Any address bit above the word-address field lies outside the data memory.
   assign out_of_range = (req_addr >> (AW + 2)) != 32'h0;
   assign req_err      = bad_align | out_of_range;

   assign Dm_A      = req_addr[AW+1:2];
   assign Dm_Din    = lane_din;
   assign Rsp_Rdata = rsp_rdata;
   assign Rsp_Err   = rsp_err;
   assign Err_Cnt   = err_cnt;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      Req_Ready = 1'b0;
      Rsp_Valid = 1'b0;
      Dm_We     = 1'b0;
      Dm_BE     = 4'b0000;
      case (state)
         ST_IDLE: begin
            Req_Ready = 1'b1;
            if (Req_Valid) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_nxt = ST_RESP;
            if (req_we && !req_err) begin
               Dm_We = 1'b1;
               Dm_BE = lane_be;
            end
         end
         ST_RESP: begin
            Rsp_Valid = 1'b1;
            if (Rsp_Ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         req_we    <= 1'b0;
         req_sgn   <= 1'b0;
         req_size  <= SZ_BYTE;
         req_addr  <= 32'h0;
         req_wdata <= 32'h0;
      end else if (state == ST_IDLE && Req_Valid) begin
         req_we    <= Req_We;
         req_sgn   <= Req_Signed;
         req_size  <= size_e'(Req_Size);
         req_addr  <= Req_Addr;
         req_wdata <= Req_Wdata;
      end
   end

   // Response and error count update on the ACCESS -> RESP transition only.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         err_cnt   <= 8'h0;
      end else if (state == ST_ACCESS) begin
         rsp_err   <= req_err;
         rsp_rdata <= (req_we || req_err) ? 32'h0 : lane_rdata;
         if (req_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule
